sdp_ram_pipe: RTL and testbench
===============================

// Module: sdp_ram_pipe
// PURPOSE
//   Parametrised simple-dual-port RAM, next generation of the 8-bit single-clock SDP buffer.
//   - Port A writes, with a per-byte write mask.
//   - Port B reads, with an optional output pipeline register and a read-valid strobe.
//   - The read-during-write collision policy is selectable.
//   - After reset, an FSM zeroes every RAM word before the block accepts traffic.
//   - Sits between the SPI front-end and the packet/scratch consumers as the shared buffer.
// PARAMETERS
//   DATAW     32  data width in bits; must be a multiple of 8
//   ADDRL     14  address width; depth = 2**ADDRL words
//   NEG_EDGE   1  1: all state updates on negedge clk; 0: all on posedge clk
//   OUT_REG    0  1: extra output register; read latency becomes 2
//   RDW_MODE   0  same-address collision: 0 = old data, 1 = new (write-through) data
//   INIT_CLR   1  1: zero the whole RAM after reset; 0: skip clearing (contents undefined)
// PORTS
//   clk        in   1         single clock; active edge selected by NEG_EDGE
//   rst_n      in   1         synchronous, active-low reset, sampled on the active edge
//   ena        in   1         port A enable
//   wea        in   1         write strobe; a write occurs when ena & wea & !busy
//   wmask      in   DATAW/8   byte write mask; bit i enables dia[8i+7:8i]
//   addra      in   ADDRL     write address
//   dia        in   DATAW     write data
//   enb        in   1         read request; accepted when enb & !busy
//   addrb      in   ADDRL     read address
//   dob        out  DATAW     read data
//   dob_valid  out  1         one-cycle strobe: dob carries data of an accepted read
//   busy       out  1         high while the init-clear is running; all requests are ignored
// BEHAVIOUR
//   Timing
//   - All registers update on the single active edge. There is no mixed-edge logic.
//   Reset (rst_n=0 at the active edge)
//   - dob=0, dob_valid=0, pipeline valids=0, clr_addr=0.
//   - state = CLEAR if INIT_CLR, else READY.
//   - busy = (state==CLEAR). busy is 1 in the first cycle after reset when INIT_CLR=1.
//   - RAM contents are not reset by the reset itself; the clear pass zeroes them.
//   FSM {CLEAR, READY}
//   - CLEAR: write all-zeros to ram[clr_addr], then clr_addr++.
//     When clr_addr == 2**ADDRL-1, that word is written and the next state is READY.
//     Clear takes exactly 2**ADDRL cycles.
//   - READY: terminal state; it is left only by reset.
//   - Reset asserted mid-clear restarts the clear at address 0.
//   Write (READY, ena & wea)
//   - ram[addra] byte i <= dia byte i for each wmask[i]=1; other bytes are unchanged.
//   - wmask=0 is a legal no-op.
//   - ena=1 with wea=0 does nothing.
//   Read (READY, enb)
//   - OUT_REG=0: dob <= ram[addrb] and dob_valid=1 on the next edge (latency 1).
//   - OUT_REG=1: data and valid are delayed by one more stage (latency 2).
//   - Back-to-back reads give one result per cycle.
//   - dob holds its last value when no read completes; dob_valid=0 in those cycles.
//   Collision (ena & wea & enb, addra==addrb, same edge)
//   - RDW_MODE=0: dob returns the pre-write word.
//   - RDW_MODE=1: dob returns the merged word: masked bytes from dia, unmasked bytes from the old word.
//   - The RAM is always updated as a normal write.
//   Requests while busy=1
//   - Ignored: no RAM write, no dob_valid.
//   - Reads issued in the cycle before CLEAR->READY are not accepted.
//   Addresses
//   - Full ADDRL width; no wrap logic is needed. Out-of-range addresses cannot occur.
// STRUCTURE
//   - Package sdp_ram_pkg:
//     - state enum {CLEAR, READY}.
//     - RDW_OLD=0 and RDW_NEW=1 constants.
//     - function nbytes(DATAW) returning DATAW/8.
//   - Sub-module sdp_ram_core:
//     - Bare storage array with byte-masked write port and registered read port, both on the selected edge.
//     - No reset inside it, so it infers block RAM.
//   - Top level holds:
//     - clear FSM, with a write mux that selects the clear path or port A;
//     - collision compare/bypass register;
//     - OUT_REG stage and valid pipeline.
// TESTING (ADDRL=4, DATAW=32 unless noted)
//   1. Reset, INIT_CLR=1 -> busy=1 for exactly 16 active edges, then 0.
//      Read all 16 addresses afterwards -> each dob=0x00000000 with dob_valid.
//   2. Write 0xDEADBEEF to addr 3 (wmask=4'hF), then read addr 3.
//      -> dob=0xDEADBEEF, dob_valid at latency 1 (OUT_REG=0) or 2 (OUT_REG=1).
//   3. Write 0x11223344 to addr 5 with wmask=4'b0101 over existing 0xAABBCCDD.
//      -> read addr 5 returns 0xAA22CC44.
//   4. Same-edge write 0x12345678 and read of addr 7, which holds 0xCAFEF00D.
//      -> RDW_MODE=0: dob=0xCAFEF00D; RDW_MODE=1: dob=0x12345678.
//      -> Either mode: a later read returns 0x12345678.
//   5. Assert rst_n=0 at clr_addr=9, then release.
//      -> busy lasts a fresh 16 cycles.
//      -> Writes/reads during busy produce no RAM change and no dob_valid.
//   6. Read stream over addrs 0..15 with enb held high, NEG_EDGE=0 and NEG_EDGE=1.
//      -> 16 consecutive dob_valid pulses with data in order.
//      -> All transitions occur only on the selected edge.

Source files
------------

// File: rtl/sdp_ram_pkg.sv
// Shared types and helpers for the simple-dual-port RAM with init-clear.
package sdp_ram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

    function automatic int nbytes(input int dataw);
        return dataw / 8;
    endfunction

endpackage

// File: rtl/sdp_ram_core.sv
// Bare storage: byte-masked write port and registered read port on one clock.
// Deliberately reset-free so it maps onto block RAM.
module sdp_ram_core
    import sdp_ram_pkg::*;
#(
    parameter int DATAW = 32,
    parameter int ADDRL = 14
) (
    input  logic               clk,
    input  logic               we,
    input  logic [DATAW/8-1:0] wmask,
    input  logic [ADDRL-1:0]   waddr,
    input  logic [DATAW-1:0]   wdata,
    input  logic               re,
    input  logic [ADDRL-1:0]   raddr,
    output logic [DATAW-1:0]   rdata
);

    localparam int NB    = nbytes(DATAW);
    localparam int DEPTH = 1 << ADDRL;

    logic [DATAW-1:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < NB; i++) begin
                if (wmask[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    // Separate read process: a same-edge collision returns the pre-write word.
    always_ff @(posedge clk) begin
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/sdp_ram_pipe.sv
// Simple-dual-port RAM wrapper: post-reset clear FSM, selectable collision
// policy and optional output register, all on one selectable clock edge.
module sdp_ram_pipe
    import sdp_ram_pkg::*;
#(
    parameter int DATAW    = 32,
    parameter int ADDRL    = 14,
    parameter int NEG_EDGE = 1,
    parameter int OUT_REG  = 0,
    parameter int RDW_MODE = 0,
    parameter int INIT_CLR = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               wea,
    input  logic [DATAW/8-1:0] wmask,
    input  logic [ADDRL-1:0]   addra,
    input  logic [DATAW-1:0]   dia,
    input  logic               enb,
    input  logic [ADDRL-1:0]   addrb,
    output logic [DATAW-1:0]   dob,
    output logic               dob_valid,
    output logic               busy
);

    localparam int NB = nbytes(DATAW);

    // Every register in the block runs off this one edge.
    logic clk_act;
    assign clk_act = (NEG_EDGE != 0) ? ~clk : clk;

    state_t           state;
    logic [ADDRL-1:0] clr_addr;
    logic             ready;
    logic             wr_req;
    logic             rd_acc;

    logic             mem_we;
    logic [NB-1:0]    mem_wmask;
    logic [ADDRL-1:0] mem_waddr;
    logic [DATAW-1:0] mem_wdata;
    logic [DATAW-1:0] core_rdata;

    logic             v1, v2, seen;
    logic             byp_sel;
    logic [DATAW-1:0] byp_dia;
    logic [NB-1:0]    byp_mask;
    logic [DATAW-1:0] stage1;
    logic [DATAW-1:0] dob_q;

    assign ready  = (state == READY);
    assign busy   = (state == CLEAR);
    assign wr_req = ready & ena & wea;
    assign rd_acc = ready & enb;

    assign mem_we    = busy | wr_req;
    assign mem_wmask = ready ? wmask : '1;
    assign mem_waddr = ready ? addra : clr_addr;
    assign mem_wdata = ready ? dia   : '0;

    always_ff @(posedge clk_act) begin
        if (!rst_n) begin
            state    <= (INIT_CLR != 0) ? CLEAR : READY;
            clr_addr <= '0;
        end else if (state == CLEAR) begin
            clr_addr <= clr_addr + 1'b1;
            if (clr_addr == '1) state <= READY;
        end
    end

    sdp_ram_core #(
        .DATAW (DATAW),
        .ADDRL (ADDRL)
    ) u_core (
        .clk   (clk_act),
        .we    (mem_we),
        .wmask (mem_wmask),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .re    (rd_acc),
        .raddr (addrb),
        .rdata (core_rdata)
    );

    // On a write-through collision the written bytes are replayed over the old word.
    always_ff @(posedge clk_act) begin
        if (!rst_n) begin
            v1       <= 1'b0;
            v2       <= 1'b0;
            seen     <= 1'b0;
            byp_sel  <= 1'b0;
            byp_dia  <= '0;
            byp_mask <= '0;
            dob_q    <= '0;
        end else begin
            v1 <= rd_acc;
            v2 <= v1;
            if (rd_acc) begin
                byp_sel  <= (RDW_MODE == RDW_NEW) && wr_req && (addra == addrb);
                byp_dia  <= dia;
                byp_mask <= wmask;
                seen     <= 1'b1;
            end
            if (v1) dob_q <= stage1;
        end
    end

    always_comb begin
        stage1 = core_rdata;
        if (byp_sel) begin
            for (int i = 0; i < NB; i++) begin
                if (byp_mask[i]) stage1[8*i +: 8] = byp_dia[8*i +: 8];
            end
        end
    end

    // Without the output register, dob reads zero until the first read after reset.
    assign dob       = (OUT_REG != 0) ? dob_q : (seen ? stage1 : '0);
    assign dob_valid = (OUT_REG != 0) ? v2 : v1;

endmodule

// File: tb/tb_sdp_ram_pipe.sv
// Scoreboard bench: two configurations driven in lockstep, each checked
// against an array-based reference RAM by its own monitor.
module tb_sdp_ram_pipe;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        ena, wea, enb;
    logic [3:0]  wmask, addra, addrb;
    logic [31:0] dia;

    logic [31:0] dob0, dob1;
    logic        valid0, valid1, busy0, busy1;

    int total = 0;
    int bad   = 0;
    int tick  = 0;

    logic [31:0] mem_m [0:15];
    exp_t        q0 [$];
    exp_t        q1 [$];

    // dut0: posedge, latency 1, old-data collisions
    sdp_ram_pipe #(
        .DATAW(32), .ADDRL(4), .NEG_EDGE(0), .OUT_REG(0), .RDW_MODE(0), .INIT_CLR(1)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .wea(wea), .wmask(wmask),
        .addra(addra), .dia(dia), .enb(enb), .addrb(addrb),
        .dob(dob0), .dob_valid(valid0), .busy(busy0)
    );

    // dut1: negedge, latency 2, write-through collisions
    sdp_ram_pipe #(
        .DATAW(32), .ADDRL(4), .NEG_EDGE(1), .OUT_REG(1), .RDW_MODE(1), .INIT_CLR(1)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .wea(wea), .wmask(wmask),
        .addra(addra), .dia(dia), .enb(enb), .addrb(addrb),
        .dob(dob1), .dob_valid(valid1), .busy(busy1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    // Drive one request cycle; acc says whether the block is expected to accept it.
    task automatic step(input logic e, input logic w, input logic [3:0] m, input logic [3:0] aa,
                        input logic [31:0] d, input logic eb, input logic [3:0] ab, input bit acc);
        logic [31:0] old, nw;
        ena = e; wea = w; wmask = m; addra = aa; dia = d; enb = eb; addrb = ab;
        if (acc) begin
            old = mem_m[ab];
            nw  = merge(mem_m[aa], d, m);
            if (eb) begin
                q0.push_back('{old, tick});
                q1.push_back('{(e && w && aa == ab) ? nw : old, tick + 1});
            end
            if (e && w) mem_m[aa] = nw;
        end
        @(posedge clk);
        #2;
        tick++;
    endtask

    task automatic garbage(input int n);
        for (int i = 0; i < n; i++)
            step(1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom), $urandom,
                 1'($urandom), 4'($urandom), 1'b0);
    endtask

    task automatic rd(input logic [3:0] a);
        step(1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b1, a, 1'b1);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] m);
        step(1'b1, 1'b1, m, a, d, 1'b0, 4'h0, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0, 1'b1);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) mem_m[i] = 32'h0;
    endtask

    // dut0 monitor, just after its posedge
    int   bcnt0 = 0;
    logic pbusy0 = 1'b0;
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            chk("dut0 reset busy", {31'b0, busy0}, 32'd1);
            chk("dut0 reset valid", {31'b0, valid0}, 32'd0);
            chk("dut0 reset dob", dob0, 32'h0);
            bcnt0 = 0;
        end else begin
            if (pbusy0) bcnt0++;
            if (pbusy0 && !busy0) begin
                chk("dut0 busy length", bcnt0, 32'd16);
                bcnt0 = 0;
            end
            if (valid0) begin
                if (q0.size() == 0) begin
                    total++; bad++;
                    $display("FAIL dut0 spurious dob_valid: got 1 want 0 (t=%0t)", $time);
                end else begin
                    chk("dut0 latency", tick, q0[0].due);
                    chk("dut0 data", dob0, q0[0].data);
                    void'(q0.pop_front());
                end
            end else if (q0.size() != 0 && q0[0].due <= tick) begin
                total++; bad++;
                $display("FAIL dut0 missing dob_valid: got 0 want 1 (t=%0t)", $time);
                void'(q0.pop_front());
            end
        end
        pbusy0 = busy0;
    end

    // dut1 monitor, just after its negedge
    int   bcnt1 = 0;
    logic pbusy1 = 1'b0;
    always @(negedge clk) begin
        #1;
        if (!rst_n) begin
            chk("dut1 reset busy", {31'b0, busy1}, 32'd1);
            chk("dut1 reset valid", {31'b0, valid1}, 32'd0);
            chk("dut1 reset dob", dob1, 32'h0);
            bcnt1 = 0;
        end else begin
            if (pbusy1) bcnt1++;
            if (pbusy1 && !busy1) begin
                chk("dut1 busy length", bcnt1, 32'd16);
                bcnt1 = 0;
            end
            if (valid1) begin
                if (q1.size() == 0) begin
                    total++; bad++;
                    $display("FAIL dut1 spurious dob_valid: got 1 want 0 (t=%0t)", $time);
                end else begin
                    chk("dut1 latency", tick, q1[0].due);
                    chk("dut1 data", dob1, q1[0].data);
                    void'(q1.pop_front());
                end
            end else if (q1.size() != 0 && q1[0].due <= tick) begin
                total++; bad++;
                $display("FAIL dut1 missing dob_valid: got 0 want 1 (t=%0t)", $time);
                void'(q1.pop_front());
            end
        end
        pbusy1 = busy1;
    end

    // Outputs must not move on the inactive edge of each instance.
    logic [33:0] snap0, snap1;
    always @(negedge clk) begin
        #4 snap1 = {dob1, valid1, busy1};
        #2 chk("dut1 inactive-edge hold", 32'({dob1, valid1, busy1} ^ snap1), 32'h0);
    end
    always @(posedge clk) begin
        #4 snap0 = {dob0, valid0, busy0};
        #2 chk("dut0 inactive-edge hold", 32'({dob0, valid0, busy0} ^ snap0), 32'h0);
    end

    initial begin
        rst_n = 1'b0;
        ena = 0; wea = 0; enb = 0; wmask = 0; addra = 0; addrb = 0; dia = 0;
        @(posedge clk);
        #2;
        garbage(3);
        rst_n = 1'b1;
        garbage(16);
        model_clear();

        for (int a = 0; a < 16; a++) rd(4'(a));
        idle(2);

        wr(4'd3, 32'hDEADBEEF, 4'hF);
        rd(4'd3);
        idle(3);

        wr(4'd5, 32'hAABBCCDD, 4'hF);
        wr(4'd5, 32'h11223344, 4'b0101);
        rd(4'd5);
        wr(4'd6, 32'h55555555, 4'h0);
        step(1'b1, 1'b0, 4'hF, 4'd6, 32'h66666666, 1'b1, 4'd6, 1'b1);
        idle(2);

        wr(4'd7, 32'hCAFEF00D, 4'hF);
        step(1'b1, 1'b1, 4'hF, 4'd7, 32'h12345678, 1'b1, 4'd7, 1'b1);
        rd(4'd7);
        wr(4'd8, 32'h01020304, 4'hF);
        step(1'b1, 1'b1, 4'b1010, 4'd8, 32'hA0B0C0D0, 1'b1, 4'd8, 1'b1);
        idle(2);

        for (int i = 0; i < 400; i++) begin
            logic [3:0] aa, ab;
            aa = 4'($urandom);
            ab = ($urandom_range(0, 3) == 0) ? aa : 4'($urandom);
            step(1'($urandom), 1'($urandom), 4'($urandom), aa, $urandom, 1'($urandom), ab, 1'b1);
        end
        idle(3);

        for (int a = 0; a < 16; a++) rd(4'(a));
        idle(3);

        rst_n = 1'b0;
        garbage(2);
        rst_n = 1'b1;
        garbage(9);
        rst_n = 1'b0;
        garbage(1);
        rst_n = 1'b1;
        garbage(16);
        model_clear();
        for (int a = 0; a < 16; a++) rd(4'(a));
        idle(5);

        chk("dut0 queue drained", q0.size(), 32'd0);
        chk("dut1 queue drained", q1.size(), 32'd0);
        chk("dut0 idle busy", {31'b0, busy0}, 32'd0);
        chk("dut1 idle busy", {31'b0, busy1}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
